move_arbiter: RTL
=================

MOVE_ARBITER -- requirements
Module: move_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, the number of IDLE cycles before the turn owner forfeits (used only when MOVE_TIMEOUT_EN is defined).
REQ-002 The block SHALL have one clock and an asynchronous active-low reset, with ports as follows.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- ai_en  in  1  AI plays O; quasi-static, changed only while reset is asserted.
- h_valid  in  1  human move offered.
- h_ready  out  1  human move accepted this cycle if h_valid is also 1.
- h_xoro / h_row / h_col  in  2 each  human mark, row, column.
- ai_valid  in  1  AI move offered.
- ai_ready  out  1  AI move accepted this cycle if ai_valid is also 1.
- ai_row / ai_col  in  2 each  AI row and column.
- ai_start  out  1  one-cycle pulse requesting the AI to compute a move.
- cells  in  18  board contents; cell (r,c) at bits [2*(3r+c)+1 : 2*(3r+c)].
- win  in  2  X=10, O=01, tie=11, none=00.
- wr_en  out  1  one-cycle board write strobe.
- wr_row / wr_col / wr_xoro  out  2 each  write address and mark.
- turn  out  2  current owner: X=10, O=01.
- err  out  1  one-cycle rejected-move pulse.
- timeout  out  1  one-cycle forfeit pulse.

Function
REQ-003 The FSM SHALL have the states IDLE, CHECK, COMMIT, SETTLE and OVER.
REQ-004 The owner SHALL be AI when turn=O and ai_en=1; otherwise the owner SHALL be human.
REQ-005 h_ready SHALL be (state==IDLE & owner human), and ai_ready SHALL be (state==IDLE & owner AI); the two are never both 1.
REQ-006 On valid&ready the block SHALL latch row, col and mark, and go to CHECK. The mark is h_xoro for a human move and 01 for an AI move.
REQ-007 In CHECK, a move SHALL be illegal if any of the following holds: row==11, col==11, mark!=turn, or the addressed cell is non-zero.
REQ-008 An illegal move in CHECK SHALL pulse err, return to IDLE and leave turn unchanged.
REQ-009 A legal move in CHECK SHALL go to COMMIT.
REQ-010 COMMIT SHALL assert wr_en for exactly one cycle with the latched address and mark, toggle turn, then go to SETTLE.
REQ-011 Latency: acceptance at cycle n gives wr_en at n+2, SETTLE at n+3, and IDLE (ready re-asserted) at n+4.
REQ-012 In SETTLE, win!=00 SHALL go to OVER; otherwise SETTLE SHALL go to IDLE.
REQ-013 ai_start SHALL pulse in the first cycle of IDLE whenever the owner is AI, including re-entry after an AI illegal move.
REQ-014 In OVER both readies SHALL be 0, and each cycle with h_valid or ai_valid at 1 SHALL pulse err; OVER is left only by reset.
REQ-015 Valid inputs in CHECK, COMMIT and SETTLE SHALL be ignored without err.

Reset
REQ-016 Reset SHALL force state=IDLE, turn=10, and wr_en=err=ai_start=timeout=0.
REQ-017 Reset SHALL clear wr_row/wr_col/wr_xoro to 00 and the timeout counter to 0.
REQ-018 After reset release, h_ready SHALL be 1, since X moves first and is always human.
REQ-019 Reset asserted in any state, including mid-COMMIT, SHALL abort the move with no further wr_en.

Configuration
REQ-020 With MOVE_TIMEOUT_EN defined, a counter SHALL increment on each IDLE cycle and clear on acceptance or on leaving IDLE.
REQ-021 With MOVE_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES-1 in IDLE without acceptance, the block SHALL pulse timeout, toggle turn, clear the counter and stay in IDLE.
REQ-022 If acceptance and expiry occur in the same cycle, acceptance SHALL win and timeout SHALL not pulse.
REQ-023 Without MOVE_TIMEOUT_EN, timeout SHALL be tied 0 and no counter logic SHALL exist.

Structure
REQ-024 Shared package ttt_pkg SHALL hold the cell codes (EMPTY=00, X=10, O=01, TIE=11) and the arbiter state enum.
REQ-025 The timeout counter SHALL be a sub-module turn_timer, instantiated only under MOVE_TIMEOUT_EN.

Verification
REQ-026 Reset, then human move X at (0,0) with cells=0: wr_en=1 two cycles later with row/col 00/00 and mark 10; turn=01 afterwards.
REQ-027 ai_en=1, X move done: ai_start pulses on IDLE entry; AI move (1,1) produces wr_en with wr_xoro=01, then turn=10.
REQ-028 Human offers mark 01 on X's turn, or row=11, or an occupied cell: err pulses once, no wr_en, turn unchanged, h_ready back at n+2.
REQ-029 win=10 presented during SETTLE: state goes to OVER; a later h_valid=1 gives err=1 and h_ready=0 until reset.
REQ-030 With MOVE_TIMEOUT_EN and TIMEOUT_CYCLES=4, human idle for 4 cycles: timeout pulses on the 4th IDLE cycle and turn flips 10->01; h_valid on that same cycle suppresses the timeout.
REQ-031 Reset asserted during COMMIT: wr_en drops immediately, turn=10, and state is IDLE after release.

Source files
------------

// File: rtl/ttt_pkg.sv
// ttt_pkg: shared definitions for the tic-tac-toe move arbiter.
//   - 2-bit cell codes used on the board bus, the turn output and the win input
//   - arbiter FSM state enum
//   - helpers to read one cell out of the packed board bus and to name the
//     opposing mark
package ttt_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b10;
    localparam logic [1:0] CELL_O     = 2'b01;
    localparam logic [1:0] CELL_TIE   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_COMMIT = 3'd2,
        ST_SETTLE = 3'd3,
        ST_OVER   = 3'd4
    } arb_state_e;

    // Cell (r,c) lives at bits [2*(3r+c)+1 : 2*(3r+c)]. Row or column 3 does
    // not exist, so those addresses read back as empty; they are rejected
    // separately by the legality check.
    function automatic logic [1:0] cell_at(input logic [17:0] cells,
                                           input logic [1:0]  row,
                                           input logic [1:0]  col);
        logic [3:0] idx;
        idx     = ({2'b00, row} * 4'd3) + {2'b00, col};
        cell_at = CELL_EMPTY;
        if ((row != 2'b11) && (col != 2'b11)) begin
            cell_at = cells[{idx, 1'b0} +: 2];
        end
    endfunction

    function automatic logic [1:0] other_mark(input logic [1:0] m);
        return (m == CELL_X) ? CELL_O : CELL_X;
    endfunction

endpackage

// File: rtl/turn_timer.sv
// turn_timer: counts consecutive IDLE cycles of the turn owner and flags
// expiry when the owner has sat idle for TIMEOUT_CYCLES cycles.
// Only instantiated when MOVE_TIMEOUT_EN is defined.
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset (clears the count)
//   idle_i    in   arbiter is in IDLE this cycle
//   accept_i  in   a move is accepted this cycle (wins over expiry)
//   expire_o  out  combinational expiry flag for this cycle
module turn_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic idle_i,
    input  logic accept_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expire_o = idle_i && !accept_i && (cnt_q == LAST);

    // Count only while idle; acceptance, expiry and leaving IDLE all restart
    // the budget from zero.
    always_comb begin
        cnt_d = '0;
        if (idle_i && !accept_i && !expire_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/move_arbiter.sv
// move_arbiter: arbitrates human and AI tic-tac-toe moves, checks legality
// against the board, issues a single board write per legal move, tracks whose
// turn it is and latches game-over.
// Optional feature: define MOVE_TIMEOUT_EN to forfeit the turn after
// TIMEOUT_CYCLES idle cycles (otherwise timeout is tied 0).
// Ports:
//   clk, reset (async, active-low)
//   ai_en                       AI plays O (static outside reset)
//   h_valid/h_ready, h_xoro/h_row/h_col      human move handshake
//   ai_valid/ai_ready, ai_row/ai_col         AI move handshake (mark is O)
//   ai_start                    one-cycle request for the AI to compute
//   cells[17:0], win[1:0]       board contents and game result
//   wr_en, wr_row/wr_col/wr_xoro board write strobe and payload
//   turn[1:0]                   current owner (X=10, O=01)
//   err, timeout                one-cycle reject / forfeit pulses
module move_arbiter
    import ttt_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ai_en,
    input  logic        h_valid,
    output logic        h_ready,
    input  logic [1:0]  h_xoro,
    input  logic [1:0]  h_row,
    input  logic [1:0]  h_col,
    input  logic        ai_valid,
    output logic        ai_ready,
    input  logic [1:0]  ai_row,
    input  logic [1:0]  ai_col,
    output logic        ai_start,
    input  logic [17:0] cells,
    input  logic [1:0]  win,
    output logic        wr_en,
    output logic [1:0]  wr_row,
    output logic [1:0]  wr_col,
    output logic [1:0]  wr_xoro,
    output logic [1:0]  turn,
    output logic        err,
    output logic        timeout
);

    // A zero-cycle budget could never be met by any player.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("move_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_e state_q, state_d;
    logic [1:0] turn_q, turn_d;
    logic [1:0] row_q, row_d;
    logic [1:0] col_q, col_d;
    logic [1:0] mark_q, mark_d;
    logic       first_q, first_d;   // current cycle is the first of an IDLE stint

    logic owner_ai, in_idle, h_acc, ai_acc, accept, illegal, expire;

    assign owner_ai = ai_en && (turn_q == CELL_O);
    assign in_idle  = (state_q == ST_IDLE);
    assign h_acc    = in_idle && !owner_ai && h_valid;
    assign ai_acc   = in_idle && owner_ai && ai_valid;
    assign accept   = h_acc || ai_acc;
    assign illegal  = (row_q == 2'b11) || (col_q == 2'b11) || (mark_q != turn_q)
                   || (cell_at(cells, row_q, col_q) != CELL_EMPTY);

`ifdef MOVE_TIMEOUT_EN
    turn_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_turn_timer (
        .clk      (clk),
        .rst_n    (reset),
        .idle_i   (in_idle),
        .accept_i (accept),
        .expire_o (expire)
    );
`else
    assign expire = 1'b0;
`endif

    // State and move registers. Reset aborts any move in flight, so a reset
    // during COMMIT drops wr_en immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            turn_q  <= CELL_X;
            row_q   <= 2'b00;
            col_q   <= 2'b00;
            mark_q  <= CELL_EMPTY;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            turn_q  <= turn_d;
            row_q   <= row_d;
            col_q   <= col_d;
            mark_q  <= mark_d;
            first_q <= first_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        turn_d  = turn_q;
        row_d   = row_q;
        col_d   = col_q;
        mark_d  = mark_q;
        case (state_q)
            ST_IDLE: begin
                if (h_acc) begin
                    row_d   = h_row;
                    col_d   = h_col;
                    mark_d  = h_xoro;
                    state_d = ST_CHECK;
                end else if (ai_acc) begin
                    row_d   = ai_row;
                    col_d   = ai_col;
                    mark_d  = CELL_O;
                    state_d = ST_CHECK;
                end else if (expire) begin
                    turn_d  = other_mark(turn_q);
                end
            end
            ST_CHECK:  state_d = illegal ? ST_IDLE : ST_COMMIT;
            ST_COMMIT: begin
                turn_d  = other_mark(turn_q);
                state_d = ST_SETTLE;
            end
            ST_SETTLE: state_d = (win != CELL_EMPTY) ? ST_OVER : ST_IDLE;
            ST_OVER:   state_d = ST_OVER;
            default:   state_d = ST_IDLE;
        endcase
        // A forfeit hands the turn to the other side, which counts as a fresh
        // IDLE entry so a newly-owning AI gets its start request.
        first_d = (state_d == ST_IDLE) && ((state_q != ST_IDLE) || expire);
    end

    // Outputs.
    always_comb begin
        h_ready  = in_idle && !owner_ai;
        ai_ready = in_idle && owner_ai;
        ai_start = in_idle && first_q && owner_ai;
        wr_en    = (state_q == ST_COMMIT);
        wr_row   = row_q;
        wr_col   = col_q;
        wr_xoro  = mark_q;
        turn     = turn_q;
        err      = ((state_q == ST_CHECK) && illegal)
                || ((state_q == ST_OVER) && (h_valid || ai_valid));
        timeout  = expire;
    end

endmodule
